// File: rtl/mem_stage_pkg.sv
// mem_stage_pkg
// Purpose : shared types and constants for the memory pipeline stage.
// Contents: mem_state_t (IDLE/WAIT), ADDR_LSB (word-alignment bit count),
//           is_misaligned() helper used when the alignment check is built in.
package mem_stage_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        WAIT = 1'b1
    } mem_state_t;

    localparam int ADDR_LSB = 2;

    function automatic logic is_misaligned(input logic [ADDR_LSB-1:0] lsb);
        return |lsb;
    endfunction

endpackage

// File: rtl/mem_stage_if.sv
// mem_stage_if
// Purpose : bundles every non-clock signal of the memory stage.
// Groups  : E/M bundle in (REG_WRITE_M, MEM_TO_REG_M, MEM_WRITE_M, ALU_OUT_M,
//           WRITE_DATA_M, WRITE_REG_M), data-memory request/ack port
//           (MEM_REQ, MEM_WE, MEM_ADDR, MEM_WDATA, MEM_ACK, MEM_RDATA),
//           STALL back to pipe_em, M/W bundle out (REG_WRITE_W, WRITE_REG_W,
//           RESULT_W, ERR_W).
// Modports: slave  = the mem_stage itself
//           master = its environment (pipe_em, data memory, register file)
interface mem_stage_if #(
    parameter int WIDTH = 32,
    parameter int REGW  = 5
);
    logic             REG_WRITE_M;
    logic             MEM_TO_REG_M;
    logic             MEM_WRITE_M;
    logic [WIDTH-1:0] ALU_OUT_M;
    logic [WIDTH-1:0] WRITE_DATA_M;
    logic [REGW-1:0]  WRITE_REG_M;

    logic             MEM_REQ;
    logic             MEM_WE;
    logic [WIDTH-1:0] MEM_ADDR;
    logic [WIDTH-1:0] MEM_WDATA;
    logic             MEM_ACK;
    logic [WIDTH-1:0] MEM_RDATA;

    logic             STALL;

    logic             REG_WRITE_W;
    logic [REGW-1:0]  WRITE_REG_W;
    logic [WIDTH-1:0] RESULT_W;
    logic             ERR_W;

    modport slave (
        input  REG_WRITE_M, MEM_TO_REG_M, MEM_WRITE_M, ALU_OUT_M, WRITE_DATA_M, WRITE_REG_M,
        output MEM_REQ, MEM_WE, MEM_ADDR, MEM_WDATA,
        input  MEM_ACK, MEM_RDATA,
        output STALL,
        output REG_WRITE_W, WRITE_REG_W, RESULT_W, ERR_W
    );

    modport master (
        output REG_WRITE_M, MEM_TO_REG_M, MEM_WRITE_M, ALU_OUT_M, WRITE_DATA_M, WRITE_REG_M,
        input  MEM_REQ, MEM_WE, MEM_ADDR, MEM_WDATA,
        output MEM_ACK, MEM_RDATA,
        input  STALL,
        input  REG_WRITE_W, WRITE_REG_W, RESULT_W, ERR_W
    );

endinterface

// File: rtl/mem_stage_pipe_mw.sv
// pipe_mw
// Purpose : M/W pipeline register with synchronous clear and bubble insert.
// Ports   : clk, clr        - clock, synchronous active-high clear
//           bubble          - load a bubble (reg_write and err forced 0)
//           next_reg_write, next_write_reg, next_result, next_err - bundle to load
//           reg_write, write_reg, result, err                      - registered bundle
module pipe_mw #(
    parameter int WIDTH = 32,
    parameter int REGW  = 5
) (
    input  logic             clk,
    input  logic             clr,
    input  logic             bubble,
    input  logic             next_reg_write,
    input  logic [REGW-1:0]  next_write_reg,
    input  logic [WIDTH-1:0] next_result,
    input  logic             next_err,
    output logic             reg_write,
    output logic [REGW-1:0]  write_reg,
    output logic [WIDTH-1:0] result,
    output logic             err
);

    always_ff @(posedge clk) begin
        if (clr) begin
            reg_write <= 1'b0;
            write_reg <= '0;
            result    <= '0;
            err       <= 1'b0;
        end else if (bubble) begin
            // Only the enables matter for a bubble; index/result are left as-is.
            reg_write <= 1'b0;
            err       <= 1'b0;
        end else begin
            reg_write <= next_reg_write;
            write_reg <= next_write_reg;
            result    <= next_result;
            err       <= next_err;
        end
    end

endmodule

// File: rtl/mem_stage.sv
// mem_stage
// Purpose : memory stage downstream of pipe_em. Issues loads/stores over a
//           request/ack port with variable latency, stalls upstream while an
//           access is outstanding, and registers the M/W bundle with the
//           writeback result already selected.
// Ports   : CLK  - clock, all state updates on rising edge
//           CLR  - synchronous active-high reset
//           bus  - mem_stage_if.slave (E/M in, memory port, STALL, M/W out)
// Option  : MEM_STAGE_ALIGN_CHECK_EN - when defined, a load/store whose
//           address is not word aligned issues no request and raises ERR_W
//           for one cycle instead. When undefined ERR_W stays 0.
//
// state | meaning
// IDLE  | no access outstanding; non-memory ops pass straight to W
// WAIT  | request on the bus, waiting for MEM_ACK
module mem_stage
    import mem_stage_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int REGW  = 5
) (
    input  logic        CLK,
    input  logic        CLR,
    mem_stage_if.slave  bus
);

    mem_state_t       state;
    logic             mem_req;
    logic             mem_we;
    logic [WIDTH-1:0] mem_addr;
    logic [WIDTH-1:0] mem_wdata;

    // Pending bundle; the pending ALU_OUT is the same value as mem_addr.
    logic             pend_reg_write;
    logic             pend_mem_to_reg;
    logic [REGW-1:0]  pend_write_reg;

    logic             acc;
    logic             misaligned;

    logic             w_bubble;
    logic             w_reg_write;
    logic [REGW-1:0]  w_write_reg;
    logic [WIDTH-1:0] w_result;
    logic             w_err;

    assign acc = bus.MEM_TO_REG_M | bus.MEM_WRITE_M;

`ifdef MEM_STAGE_ALIGN_CHECK_EN
    assign misaligned = acc && is_misaligned(bus.ALU_OUT_M[ADDR_LSB-1:0]);
`else
    assign misaligned = 1'b0;
`endif

    // A misaligned access is rejected in the same cycle, so it never stalls.
    assign bus.STALL = !CLR &&
                       (((state == IDLE) && acc && !misaligned) ||
                        ((state == WAIT) && !bus.MEM_ACK));

    always_ff @(posedge CLK) begin
        if (CLR) begin
            state           <= IDLE;
            mem_req         <= 1'b0;
            mem_we          <= 1'b0;
            mem_addr        <= '0;
            mem_wdata       <= '0;
            pend_reg_write  <= 1'b0;
            pend_mem_to_reg <= 1'b0;
            pend_write_reg  <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (acc && !misaligned) begin
                        mem_req         <= 1'b1;
                        mem_we          <= bus.MEM_WRITE_M;
                        mem_addr        <= bus.ALU_OUT_M;
                        mem_wdata       <= bus.WRITE_DATA_M;
                        pend_reg_write  <= bus.REG_WRITE_M;
                        pend_mem_to_reg <= bus.MEM_TO_REG_M;
                        pend_write_reg  <= bus.WRITE_REG_M;
                        state           <= WAIT;
                    end
                end
                WAIT: begin
                    if (bus.MEM_ACK) begin
                        mem_req <= 1'b0;
                        state   <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    always_comb begin
        w_bubble    = 1'b1;
        w_reg_write = 1'b0;
        w_write_reg = bus.WRITE_REG_M;
        w_result    = bus.ALU_OUT_M;
        w_err       = 1'b0;
        case (state)
            IDLE: begin
                if (!acc) begin
                    w_bubble    = 1'b0;
                    w_reg_write = bus.REG_WRITE_M;
                end else if (misaligned) begin
                    w_bubble = 1'b0;
                    w_err    = 1'b1;
                end
            end
            WAIT: begin
                if (bus.MEM_ACK) begin
                    w_bubble    = 1'b0;
                    w_reg_write = pend_reg_write;
                    w_write_reg = pend_write_reg;
                    w_result    = pend_mem_to_reg ? bus.MEM_RDATA : mem_addr;
                end
            end
            default: w_bubble = 1'b1;
        endcase
    end

    assign bus.MEM_REQ   = mem_req;
    assign bus.MEM_WE    = mem_we;
    assign bus.MEM_ADDR  = mem_addr;
    assign bus.MEM_WDATA = mem_wdata;

    pipe_mw #(
        .WIDTH (WIDTH),
        .REGW  (REGW)
    ) u_pipe_mw (
        .clk            (CLK),
        .clr            (CLR),
        .bubble         (w_bubble),
        .next_reg_write (w_reg_write),
        .next_write_reg (w_write_reg),
        .next_result    (w_result),
        .next_err       (w_err),
        .reg_write      (bus.REG_WRITE_W),
        .write_reg      (bus.WRITE_REG_W),
        .result         (bus.RESULT_W),
        .err            (bus.ERR_W)
    );

endmodule

// File: tb/tb_mem_stage.sv
// tb_mem_stage
// Purpose : directed bench for mem_stage. Stimulus pushes expected writebacks
//           into a queue; a negedge monitor pops and compares whenever the
//           DUT presents REG_WRITE_W or ERR_W. Request-side behaviour is
//           checked inline by the stimulus tasks.
module tb_mem_stage;

    typedef struct {
        logic        rw;
        logic [4:0]  wr;
        logic [31:0] res;
        logic        err;
    } wb_t;

    logic CLK;
    logic CLR;
    int   tests;
    int   fails;
    wb_t  exp_q[$];

    mem_stage_if #(.WIDTH(32), .REGW(5)) bus ();

    mem_stage #(.WIDTH(32), .REGW(5)) dut (
        .CLK (CLK),
        .CLR (CLR),
        .bus (bus)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    function automatic void check(input string name, input logic [31:0] act, input logic [31:0] req);
        tests++;
        if (act !== req) begin
            fails++;
            $display("FAIL %s actual=%h required=%h at %0t", name, act, req, $time);
        end
    endfunction

    // Scoreboard monitor
    always @(negedge CLK) begin
        if (!CLR && (bus.REG_WRITE_W === 1'b1 || bus.ERR_W === 1'b1)) begin
            if (exp_q.size() == 0) begin
                check("unexpected_wb", {30'd0, bus.ERR_W, bus.REG_WRITE_W}, 32'd0);
            end else begin
                wb_t e;
                e = exp_q.pop_front();
                check("wb_reg_write", {31'd0, bus.REG_WRITE_W}, {31'd0, e.rw});
                check("wb_err", {31'd0, bus.ERR_W}, {31'd0, e.err});
                if (e.rw) begin
                    check("wb_write_reg", {27'd0, bus.WRITE_REG_W}, {27'd0, e.wr});
                    check("wb_result", bus.RESULT_W, e.res);
                end
            end
        end
    end

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic nop();
        bus.REG_WRITE_M  = 1'b0;
        bus.MEM_TO_REG_M = 1'b0;
        bus.MEM_WRITE_M  = 1'b0;
        bus.ALU_OUT_M    = '0;
        bus.WRITE_DATA_M = '0;
        bus.WRITE_REG_M  = '0;
    endtask

    task automatic alu_op(input logic [31:0] val, input logic rw, input logic [4:0] wr);
        bus.REG_WRITE_M  = rw;
        bus.MEM_TO_REG_M = 1'b0;
        bus.MEM_WRITE_M  = 1'b0;
        bus.ALU_OUT_M    = val;
        bus.WRITE_DATA_M = 32'hFFFF_0000;
        bus.WRITE_REG_M  = wr;
        if (rw) exp_q.push_back('{rw: 1'b1, wr: wr, res: val, err: 1'b0});
        @(negedge CLK);
        check("alu_stall", {31'd0, bus.STALL}, 32'd0);
        tick();
        nop();
        check("alu_no_req", {31'd0, bus.MEM_REQ}, 32'd0);
    endtask

    // Memory access presented now (cycle 0), MEM_ACK in cycle k (k >= 1).
    // Returns at the start of cycle k+1 with inputs set to nop.
    task automatic mem_op(input logic is_load, input logic [31:0] addr, input logic [31:0] wdata,
                          input logic [31:0] rdata, input logic rw, input logic [4:0] wr, input int k);
        bus.REG_WRITE_M  = rw;
        bus.MEM_TO_REG_M = is_load;
        bus.MEM_WRITE_M  = !is_load;
        bus.ALU_OUT_M    = addr;
        bus.WRITE_DATA_M = wdata;
        bus.WRITE_REG_M  = wr;
        if (rw) exp_q.push_back('{rw: 1'b1, wr: wr, res: (is_load ? rdata : addr), err: 1'b0});
        @(negedge CLK);
        check("acc_stall_c0", {31'd0, bus.STALL}, 32'd1);
        check("acc_no_req_c0", {31'd0, bus.MEM_REQ}, 32'd0);
        for (int c = 1; c <= k; c++) begin
            tick();
            if (c == k) begin
                bus.MEM_ACK   = 1'b1;
                bus.MEM_RDATA = rdata;
            end else begin
                bus.MEM_RDATA = 32'h0BAD_0BAD;
            end
            @(negedge CLK);
            check("acc_req", {31'd0, bus.MEM_REQ}, 32'd1);
            check("acc_we", {31'd0, bus.MEM_WE}, {31'd0, !is_load});
            check("acc_addr", bus.MEM_ADDR, addr);
            if (!is_load) check("acc_wdata", bus.MEM_WDATA, wdata);
            check("acc_stall", {31'd0, bus.STALL}, (c == k) ? 32'd0 : 32'd1);
            if (!rw) check("acc_no_wb", {31'd0, bus.REG_WRITE_W}, 32'd0);
        end
        tick();
        bus.MEM_ACK = 1'b0;
        nop();
        check("acc_req_drop", {31'd0, bus.MEM_REQ}, 32'd0);
        if (!rw) check("acc_no_wb_end", {31'd0, bus.REG_WRITE_W}, 32'd0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog expired at %0t", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        tests = 0;
        fails = 0;
        CLR   = 1'b1;
        bus.REG_WRITE_M  = 1'b1;
        bus.MEM_TO_REG_M = 1'b1;
        bus.MEM_WRITE_M  = $urandom_range(0, 1);
        bus.ALU_OUT_M    = $urandom;
        bus.WRITE_DATA_M = $urandom;
        bus.WRITE_REG_M  = 5'($urandom);
        bus.MEM_ACK      = 1'b1;
        bus.MEM_RDATA    = $urandom;

        // Reset
        tick();
        tick();
        @(negedge CLK);
        check("rst_stall", {31'd0, bus.STALL}, 32'd0);
        check("rst_req", {31'd0, bus.MEM_REQ}, 32'd0);
        check("rst_we", {31'd0, bus.MEM_WE}, 32'd0);
        check("rst_addr", bus.MEM_ADDR, 32'd0);
        check("rst_wdata", bus.MEM_WDATA, 32'd0);
        check("rst_reg_write", {31'd0, bus.REG_WRITE_W}, 32'd0);
        check("rst_write_reg", {27'd0, bus.WRITE_REG_W}, 32'd0);
        check("rst_result", bus.RESULT_W, 32'd0);
        check("rst_err", {31'd0, bus.ERR_W}, 32'd0);
        tick();
        CLR         = 1'b0;
        bus.MEM_ACK = 1'b0;
        nop();
        tick();

        // ALU ops
        alu_op(32'h0000_1234, 1'b1, 5'd7);
        alu_op(32'hCAFE_0001, 1'b0, 5'd3);
        alu_op(32'h8000_0000, 1'b1, 5'd31);

        // Load, ack in third cycle of the access -> STALL high 3 cycles
        mem_op(1'b1, 32'h0000_0100, 32'h0, 32'hDEAD_BEEF, 1'b1, 5'd10, 3);
        tick();

        // Store, ack in first request cycle, no writeback
        mem_op(1'b0, 32'h0000_0200, 32'hA5A5_A5A5, 32'h0, 1'b0, 5'd0, 1);
        tick();

        // Back-to-back: load then store-with-writeback presented immediately
        mem_op(1'b1, 32'h0000_0104, 32'h0, 32'h1234_5678, 1'b1, 5'd9, 2);
        mem_op(1'b0, 32'h0000_0208, 32'h0F0F_0F0F, 32'h0, 1'b1, 5'd4, 1);
        alu_op(32'h0000_0055, 1'b1, 5'd1);

        // CLR in WAIT, same cycle as MEM_ACK; later stray ack ignored
        bus.REG_WRITE_M  = 1'b1;
        bus.MEM_TO_REG_M = 1'b1;
        bus.MEM_WRITE_M  = 1'b0;
        bus.ALU_OUT_M    = 32'h0000_0300;
        bus.WRITE_REG_M  = 5'd5;
        tick();
        tick();
        CLR           = 1'b1;
        bus.MEM_ACK   = 1'b1;
        bus.MEM_RDATA = 32'h1111_2222;
        @(negedge CLK);
        check("clr_stall", {31'd0, bus.STALL}, 32'd0);
        tick();
        CLR         = 1'b0;
        bus.MEM_ACK = 1'b0;
        nop();
        check("clr_req", {31'd0, bus.MEM_REQ}, 32'd0);
        check("clr_no_wb", {31'd0, bus.REG_WRITE_W}, 32'd0);
        tick();
        bus.MEM_ACK = 1'b1;
        @(negedge CLK);
        check("stray_ack_stall", {31'd0, bus.STALL}, 32'd0);
        tick();
        bus.MEM_ACK = 1'b0;
        check("stray_ack_req", {31'd0, bus.MEM_REQ}, 32'd0);
        check("stray_ack_no_wb", {31'd0, bus.REG_WRITE_W}, 32'd0);
        tick();

        // Misaligned load
`ifdef MEM_STAGE_ALIGN_CHECK_EN
        bus.REG_WRITE_M  = 1'b1;
        bus.MEM_TO_REG_M = 1'b1;
        bus.ALU_OUT_M    = 32'h0000_0102;
        bus.WRITE_REG_M  = 5'd3;
        exp_q.push_back('{rw: 1'b0, wr: 5'd3, res: 32'h0000_0102, err: 1'b1});
        @(negedge CLK);
        check("mis_stall", {31'd0, bus.STALL}, 32'd0);
        tick();
        nop();
        @(negedge CLK);
        check("mis_err", {31'd0, bus.ERR_W}, 32'd1);
        check("mis_no_wb", {31'd0, bus.REG_WRITE_W}, 32'd0);
        check("mis_no_req", {31'd0, bus.MEM_REQ}, 32'd0);
        tick();
        @(negedge CLK);
        check("mis_err_clear", {31'd0, bus.ERR_W}, 32'd0);
        tick();
`else
        mem_op(1'b1, 32'h0000_0102, 32'h0, 32'h7777_8888, 1'b1, 5'd3, 2);
        tick();
        @(negedge CLK);
        check("noalign_err", {31'd0, bus.ERR_W}, 32'd0);
        tick();
`endif

        tick();
        tick();
        check("sb_empty", exp_q.size(), 32'd0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
